dcache_bank_ctrl: RTL and testbench



---
 rtl/dcache_bank_ctrl.sv | 121 ++++++++++++
 tb/tb_dcache_bank_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_bank_ctrl.sv
// Data-cache bank controller: shares the RAM write port between stores and
// multi-beat line refills, schedules line reads and blocks read-after-write hazards.
module dcache_bank_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_SIZE   = 1024,
    parameter int LINE_WORDS = 4,
    localparam int AW = $clog2(RAM_SIZE),
    localparam int LW = AW - $clog2(LINE_WORDS),
    localparam int BE = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             refill_req_valid,
    output logic                             refill_req_ready,
    input  logic [LW-1:0]                    refill_line,
    input  logic                             refill_data_valid,
    output logic                             refill_data_ready,
    input  logic [DATA_WIDTH-1:0]            refill_data,
    input  logic                             refill_data_last,
    output logic                             refill_done,
    output logic                             refill_err,
    input  logic                             st_valid,
    output logic                             st_ready,
    input  logic [AW-1:0]                    st_addr,
    input  logic [BE-1:0]                    st_strb,
    input  logic [DATA_WIDTH-1:0]            st_data,
    input  logic                             rd_valid,
    output logic                             rd_ready,
    input  logic [LW-1:0]                    rd_line,
    output logic                             rd_resp_valid,
    output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_resp_data,
    output logic [AW-1:0]                    ram_addr_a,
    output logic [BE-1:0]                    ram_we,
    output logic [DATA_WIDTH-1:0]            ram_din,
    output logic [LW-1:0]                    ram_addr_b,
    input  logic [LINE_WORDS*DATA_WIDTH-1:0] ram_dout,
    output logic                             fsm_state
);

    localparam int CW = $clog2(LINE_WORDS);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t          state;
    logic [LW-1:0]   fill_line;
    logic [CW-1:0]   cnt;
    logic            last_beat;
    logic            beat_hs;
    logic            st_hs;
    logic            wr_hs;

    // Handshake: a transfer happens on a rising edge where valid && ready;
    // ready never depends on the same channel's valid.
    assign refill_req_ready  = (state == IDLE);
    assign refill_data_ready = (state == FILL);
    assign st_ready          = (state == IDLE) && !refill_req_valid;
    assign beat_hs           = refill_data_valid && (state == FILL);
    assign st_hs             = st_valid && st_ready;
    assign wr_hs             = beat_hs || st_hs;
    assign last_beat         = (cnt == CW'(LINE_WORDS - 1));
    assign fsm_state         = (state == FILL);

    always_comb begin
        ram_addr_a = '0;
        ram_we     = '0;
        ram_din    = '0;
        if (beat_hs) begin
            ram_addr_a = {fill_line, cnt};
            ram_we     = '1;
            ram_din    = refill_data;
        end else if (st_hs) begin
            ram_addr_a = st_addr;
            ram_we     = st_strb;
            ram_din    = st_data;
        end
    end

    // The read port is read-first, so a same-cycle write to the line would return stale data.
    assign ram_addr_b   = rd_line;
    assign rd_ready     = !((state == FILL) && (rd_line == fill_line))
                       && !(wr_hs && (ram_addr_a[AW-1:AW-LW] == rd_line));
    assign rd_resp_data = ram_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            fill_line     <= '0;
            cnt           <= '0;
            refill_done   <= 1'b0;
            refill_err    <= 1'b0;
            rd_resp_valid <= 1'b0;
        end else begin
            refill_done   <= 1'b0;
            rd_resp_valid <= rd_valid && rd_ready;
            case (state)
                IDLE: begin
                    if (refill_req_valid) begin
                        fill_line <= refill_line;
                        cnt       <= '0;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    if (refill_data_valid) begin
                        // The beat count, not the bus marker, decides completion.
                        if (refill_data_last != last_beat) begin
                            refill_err <= 1'b1;
                        end
                        cnt <= cnt + 1'b1;
                        if (last_beat) begin
                            state       <= IDLE;
                            refill_done <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_bank_ctrl.sv
// Bench for dcache_bank_ctrl: external byte-enabled RAM model, a line-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_dcache_bank_ctrl;

    localparam int DW  = 32;
    localparam int RS  = 1024;
    localparam int LWD = 4;
    localparam int AW  = $clog2(RS);
    localparam int LW  = AW - $clog2(LWD);
    localparam int BE  = DW / 8;
    localparam int LDW = LWD * DW;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           refill_req_valid = 1'b0;
    logic           refill_req_ready;
    logic [LW-1:0]  refill_line = '0;
    logic           refill_data_valid = 1'b0;
    logic           refill_data_ready;
    logic [DW-1:0]  refill_data = '0;
    logic           refill_data_last = 1'b0;
    logic           refill_done;
    logic           refill_err;
    logic           st_valid = 1'b0;
    logic           st_ready;
    logic [AW-1:0]  st_addr = '0;
    logic [BE-1:0]  st_strb = '0;
    logic [DW-1:0]  st_data = '0;
    logic           rd_valid = 1'b0;
    logic           rd_ready;
    logic [LW-1:0]  rd_line = '0;
    logic           rd_resp_valid;
    logic [LDW-1:0] rd_resp_data;
    logic [AW-1:0]  ram_addr_a;
    logic [BE-1:0]  ram_we;
    logic [DW-1:0]  ram_din;
    logic [LW-1:0]  ram_addr_b;
    logic [LDW-1:0] ram_dout;
    logic           fsm_state;

    int n_vec  = 0;
    int n_err  = 0;
    int n_done = 0;

    dcache_bank_ctrl #(.DATA_WIDTH(DW), .RAM_SIZE(RS), .LINE_WORDS(LWD)) dut (
        .clk(clk), .rst_n(rst_n),
        .refill_req_valid(refill_req_valid), .refill_req_ready(refill_req_ready),
        .refill_line(refill_line),
        .refill_data_valid(refill_data_valid), .refill_data_ready(refill_data_ready),
        .refill_data(refill_data), .refill_data_last(refill_data_last),
        .refill_done(refill_done), .refill_err(refill_err),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_strb(st_strb), .st_data(st_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_line(rd_line),
        .rd_resp_valid(rd_resp_valid), .rd_resp_data(rd_resp_data),
        .ram_addr_a(ram_addr_a), .ram_we(ram_we), .ram_din(ram_din),
        .ram_addr_b(ram_addr_b), .ram_dout(ram_dout), .fsm_state(fsm_state)
    );

    // Clock and the external RAM: byte-enabled write, read-first registered line read.
    always #5 clk = ~clk;

    bit [DW-1:0] mem [RS];

    always @(posedge clk) begin
        for (int b = 0; b < BE; b++) begin
            if (ram_we[b]) mem[ram_addr_a][8*b +: 8] <= ram_din[8*b +: 8];
        end
        for (int w = 0; w < LWD; w++) begin
            ram_dout[w*DW +: DW] <= mem[int'(ram_addr_b) * LWD + w];
        end
    end

    task automatic chk(input string name, input logic [LDW-1:0] act, input logic [LDW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: handshake never happened at %0t", name, $time);
    endtask

    function automatic logic [LDW-1:0] mk_line(input logic [DW-1:0] w3, input logic [DW-1:0] w2,
                                               input logic [DW-1:0] w1, input logic [DW-1:0] w0);
        return {w3, w2, w1, w0};
    endfunction

    // Reference model: tracks which line is being filled and how many beats
    // have landed, keeps a golden copy of memory and a queue of expected responses.
    bit             m_filling = 1'b0;
    logic [LW-1:0]  m_line = '0;
    int             m_beats = 0;
    logic           m_err = 1'b0;
    logic           m_done = 1'b0;
    bit [DW-1:0]    gold [RS];
    logic [LDW-1:0] exp_q [$];

    always @(negedge clk) begin : compare
        logic [AW-1:0]  e_addr;
        logic [BE-1:0]  e_we;
        logic [DW-1:0]  e_din;
        logic           e_wr_hs;
        logic           e_st_ready;
        logic           e_rd_ready;
        logic [LDW-1:0] e_line;
        if (!rst_n) begin
            m_filling = 1'b0;
            m_line    = '0;
            m_beats   = 0;
            m_err     = 1'b0;
            m_done    = 1'b0;
            exp_q.delete();
        end
        e_st_ready = !m_filling && !refill_req_valid;
        e_wr_hs = 1'b0;
        e_addr  = '0;
        e_we    = '0;
        e_din   = '0;
        if (m_filling && refill_data_valid) begin
            e_wr_hs = 1'b1;
            e_addr  = AW'(int'(m_line) * LWD + m_beats);
            e_we    = '1;
            e_din   = refill_data;
        end else if (st_valid && e_st_ready) begin
            e_wr_hs = 1'b1;
            e_addr  = st_addr;
            e_we    = st_strb;
            e_din   = st_data;
        end
        e_rd_ready = !(m_filling && rd_line == m_line)
                  && !(e_wr_hs && LW'(int'(e_addr) / LWD) == rd_line);

        chk("refill_req_ready", LDW'(refill_req_ready), LDW'(!m_filling));
        chk("refill_data_ready", LDW'(refill_data_ready), LDW'(m_filling));
        chk("fsm_state", LDW'(fsm_state), LDW'(m_filling));
        chk("st_ready", LDW'(st_ready), LDW'(e_st_ready));
        chk("rd_ready", LDW'(rd_ready), LDW'(e_rd_ready));
        chk("ram_we", LDW'(ram_we), LDW'(e_we));
        chk("ram_addr_a", LDW'(ram_addr_a), LDW'(e_addr));
        chk("ram_din", LDW'(ram_din), LDW'(e_din));
        chk("ram_addr_b", LDW'(ram_addr_b), LDW'(rd_line));
        chk("refill_done", LDW'(refill_done), LDW'(m_done));
        chk("refill_err", LDW'(refill_err), LDW'(m_err));
        if (exp_q.size() > 0) begin
            e_line = exp_q.pop_front();
            chk("rd_resp_valid", LDW'(rd_resp_valid), LDW'(1));
            chk("rd_resp_data", rd_resp_data, e_line);
        end else begin
            chk("rd_resp_valid", LDW'(rd_resp_valid), LDW'(0));
        end
        if (refill_done) n_done++;

        if (rst_n) begin
            m_done = 1'b0;
            if (rd_valid && e_rd_ready) begin
                for (int w = 0; w < LWD; w++) e_line[w*DW +: DW] = gold[int'(rd_line) * LWD + w];
                exp_q.push_back(e_line);
            end
            for (int b = 0; b < BE; b++) begin
                if (e_we[b]) gold[e_addr][8*b +: 8] = e_din[8*b +: 8];
            end
            if (m_filling && refill_data_valid) begin
                if (refill_data_last != (m_beats == LWD - 1)) m_err = 1'b1;
                m_beats++;
                if (m_beats == LWD) begin
                    m_filling = 1'b0;
                    m_done    = 1'b1;
                end
            end else if (!m_filling && refill_req_valid) begin
                m_filling = 1'b1;
                m_line    = refill_line;
                m_beats   = 0;
            end
        end
    end

    // Driver tasks: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [AW-1:0] a, input logic [BE-1:0] s, input logic [DW-1:0] d);
        logic hs = 1'b0;
        st_valid = 1'b1; st_addr = a; st_strb = s; st_data = d;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = st_ready;
            tick();
        end
        if (!hs) timeout_fail("store_wait");
        st_valid = 1'b0;
    endtask

    task automatic do_req(input logic [LW-1:0] line);
        logic hs = 1'b0;
        refill_req_valid = 1'b1; refill_line = line;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = refill_req_ready;
            tick();
        end
        if (!hs) timeout_fail("req_wait");
        refill_req_valid = 1'b0;
    endtask

    task automatic do_beat(input logic [DW-1:0] d, input logic last);
        logic hs = 1'b0;
        refill_data_valid = 1'b1; refill_data = d; refill_data_last = last;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = refill_data_ready;
            tick();
        end
        if (!hs) timeout_fail("beat_wait");
        refill_data_valid = 1'b0; refill_data_last = 1'b0;
    endtask

    task automatic do_read(input logic [LW-1:0] line, output logic [LDW-1:0] resp);
        logic hs = 1'b0;
        rd_valid = 1'b1; rd_line = line;
        for (int i = 0; i < 20 && !hs; i++) begin
            @(negedge clk);
            hs = rd_ready;
            tick();
        end
        if (!hs) timeout_fail("read_wait");
        rd_valid = 1'b0;
        @(negedge clk);
        chk("read_resp_valid", LDW'(rd_resp_valid), LDW'(hs));
        resp = rd_resp_data;
        tick();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [LDW-1:0] resp;
        int d0;

        // Reset state with all requests idle.
        repeat (2) begin
            @(negedge clk);
            chk("rst_req_ready", LDW'(refill_req_ready), LDW'(1));
            chk("rst_data_ready", LDW'(refill_data_ready), LDW'(0));
            chk("rst_st_ready", LDW'(st_ready), LDW'(1));
            chk("rst_rd_ready", LDW'(rd_ready), LDW'(1));
            chk("rst_ram_we", LDW'(ram_we), LDW'(0));
            chk("rst_done", LDW'(refill_done), LDW'(0));
            chk("rst_err", LDW'(refill_err), LDW'(0));
            chk("rst_resp_valid", LDW'(rd_resp_valid), LDW'(0));
            tick();
        end
        rst_n = 1'b1;
        tick();

        // Partial-strobe store, then line read.
        do_store(AW'(5), 4'b0011, 32'hDEADBEEF);
        do_read(LW'(1), resp);
        chk("partial_store_line1", resp, mk_line(32'h0, 32'h0, 32'h0000BEEF, 32'h0));

        // Refill line 3 with a gap; probe the blocked line and another line during FILL.
        d0 = n_done;
        do_req(LW'(3));
        rd_valid = 1'b1; rd_line = LW'(3);
        @(negedge clk);
        chk("rd_block_fill_line", LDW'(rd_ready), LDW'(0));
        tick();
        rd_valid = 1'b0;
        do_read(LW'(2), resp);
        chk("rd_other_line_in_fill", resp, mk_line(32'h0, 32'h0, 32'h0, 32'h0));
        do_beat(32'h10, 1'b0);
        do_beat(32'h11, 1'b0);
        rd_valid = 1'b1; rd_line = LW'(3);
        @(negedge clk);
        chk("rd_block_fill_gap", LDW'(rd_ready), LDW'(0));
        tick();
        rd_valid = 1'b0;
        do_beat(32'h12, 1'b0);
        do_beat(32'h13, 1'b1);
        @(negedge clk);
        chk("done_after_beat3", LDW'(refill_done), LDW'(1));
        chk("idle_after_fill", LDW'(refill_req_ready), LDW'(1));
        tick();
        repeat (2) tick();
        chk("done_once", LDW'(n_done - d0), LDW'(1));
        do_read(LW'(3), resp);
        chk("refill_line3", resp, mk_line(32'h13, 32'h12, 32'h11, 32'h10));

        // Same-cycle store and read to the same line.
        st_valid = 1'b1; st_addr = AW'(9); st_strb = 4'hF; st_data = 32'hCAFE0009;
        rd_valid = 1'b1; rd_line = LW'(2);
        @(negedge clk);
        chk("raw_block", LDW'(rd_ready), LDW'(0));
        chk("raw_store_ready", LDW'(st_ready), LDW'(1));
        tick();
        st_valid = 1'b0;
        @(negedge clk);
        chk("raw_next_ready", LDW'(rd_ready), LDW'(1));
        tick();
        rd_valid = 1'b0;
        @(negedge clk);
        chk("raw_resp_valid", LDW'(rd_resp_valid), LDW'(1));
        chk("raw_resp_data", rd_resp_data, mk_line(32'h0, 32'h0, 32'hCAFE0009, 32'h0));
        tick();

        // Store and refill request together: refill wins, store lands after exit.
        refill_req_valid = 1'b1; refill_line = LW'(7);
        st_valid = 1'b1; st_addr = AW'(28); st_strb = 4'hF; st_data = 32'h55;
        @(negedge clk);
        chk("prio_st_ready", LDW'(st_ready), LDW'(0));
        chk("prio_req_ready", LDW'(refill_req_ready), LDW'(1));
        tick();
        refill_req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            refill_data_valid = 1'b1; refill_data = DW'(32'h70 + k); refill_data_last = (k == 3);
            @(negedge clk);
            chk("st_blocked_fill", LDW'(st_ready), LDW'(0));
            tick();
        end
        refill_data_valid = 1'b0; refill_data_last = 1'b0;
        @(negedge clk);
        chk("st_after_exit", LDW'(st_ready), LDW'(1));
        tick();
        st_valid = 1'b0;
        do_read(LW'(7), resp);
        chk("line7_store_after_fill", resp, mk_line(32'h73, 32'h72, 32'h71, 32'h55));

        // Last marker on beat 2: error is sticky, fill still runs four beats.
        chk("err_clear_before", LDW'(refill_err), LDW'(0));
        do_req(LW'(4));
        for (int k = 0; k < 4; k++) do_beat(DW'(32'h40 + k), k == 2);
        @(negedge clk);
        chk("err_set", LDW'(refill_err), LDW'(1));
        chk("err_fill_done", LDW'(refill_done), LDW'(1));
        tick();
        repeat (3) tick();
        chk("err_sticky", LDW'(refill_err), LDW'(1));
        do_read(LW'(4), resp);
        chk("refill_line4", resp, mk_line(32'h43, 32'h42, 32'h41, 32'h40));

        // Reset in the middle of a fill: no further writes from the remaining beats.
        do_req(LW'(5));
        do_beat(32'h50, 1'b0);
        do_beat(32'h51, 1'b0);
        rst_n = 1'b0;
        refill_data_valid = 1'b1; refill_data = 32'h52;
        @(negedge clk);
        chk("midrst_err_cleared", LDW'(refill_err), LDW'(0));
        chk("midrst_we", LDW'(ram_we), LDW'(0));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            refill_data = DW'(32'h53 + k);
            @(negedge clk);
            chk("postrst_we", LDW'(ram_we), LDW'(0));
            chk("postrst_data_ready", LDW'(refill_data_ready), LDW'(0));
            tick();
        end
        refill_data_valid = 1'b0;
        do_read(LW'(5), resp);
        chk("midrst_line5_partial", resp, mk_line(32'h0, 32'h0, 32'h51, 32'h50));

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
